// File: rtl/seg_scan_if.sv
// seg_scan_if -- bus between a scan-driver user and seg_scan_driver.
//   slowClk   : scan-rate square wave (sampled as data by the driver)
//   value     : four hex nibbles, value[3:0] is digit 0 (rightmost)
//   load      : one-cycle strobe capturing value into the shadow register
//   an        : digit anode enables, one-hot when active
//   seg       : segments {g,f,e,d,c,b,a}
//   digit_idx : index of the digit currently selected
// master drives slowClk/value/load; slave (the driver) drives an/seg/digit_idx.
interface seg_scan_if;
    logic        slowClk;
    logic [15:0] value;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  digit_idx;

    modport master (output slowClk, value, load, input an, seg, digit_idx);
    modport slave  (input slowClk, value, load, output an, seg, digit_idx);
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver -- four-digit multiplexed seven-segment scanner.
// Each rising edge of slowClk advances to the next digit. Between digits all
// anodes are held off for BLANK_CYCLES clk100Mhz cycles to avoid ghosting.
// A shadow register takes new values at any time; it is copied to the display
// register only when the scan wraps from digit 3 to digit 0, so a frame never
// mixes two values.
// Ports:
//   clk100Mhz : system clock, every flop uses its rising edge
//   reset     : asynchronous, active-high
//   bus       : seg_scan_if.slave (slowClk, value, load in; an, seg, digit_idx out)
// Parameters:
//   BLANK_CYCLES : cycles with all anodes off between digits (1..255)
//   ACTIVE_LOW   : 1 = anodes/segments active-low, 0 = active-high
// Optional build macro:
//   SEG_LEADING_ZERO_BLANK_EN : keep digits above 0 dark when that nibble and
//                               all higher nibbles are zero.
module seg_scan_driver #(
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic       clk100Mhz,
    input  logic       reset,
    seg_scan_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    // XOR masks: an active-high pattern XOR these gives the output polarity,
    // and the masks themselves are the "all off" levels.
    localparam logic [3:0] AN_OFF  = (ACTIVE_LOW != 0) ? 4'hF  : 4'h0;
    localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);

    state_t      state;
    logic        sync1, sync2, hist;
    logic        scan_tick;
    logic [7:0]  blank_cnt;
    logic [1:0]  idx;
    logic [15:0] shadow, display;
    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    logic [3:0]  nib;
    logic        lit;

    // Active-high {g,f,e,d,c,b,a} pattern for a hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // slowClk is asynchronous data: two sync flops, then a history flop for
    // rising-edge detection.
    always_ff @(posedge clk100Mhz or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= bus.slowClk;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign scan_tick = sync2 & ~hist;

    always_comb begin
        nib = display[{idx, 2'b00} +: 4];
        lit = 1'b1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        // Digit 0 always shows; higher digits only if something at or above
        // them is non-zero.
        lit = (idx == 2'd0) || ((display >> {idx, 2'b00}) != 16'h0000);
`endif
    end

    always_ff @(posedge clk100Mhz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            blank_cnt <= 8'd0;
            idx       <= 2'd3;  // so the first tick wraps to 0 and loads display
            shadow    <= 16'h0000;
            display   <= 16'h0000;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
        end else begin
            if (bus.load)
                shadow <= bus.value;

            case (state)
                IDLE, DRIVE: begin
                    if (scan_tick) begin
                        state     <= BLANK;
                        blank_cnt <= 8'd0;
                        idx       <= idx + 2'd1;
                        // Non-blocking read: a coincident load lands next frame.
                        if (idx == 2'd3)
                            display <= shadow;
                    end
                end
                BLANK: begin
                    // Ticks here are deliberately ignored.
                    if (blank_cnt == BLANK_LAST)
                        state <= DRIVE;
                    else
                        blank_cnt <= blank_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase

            // Outputs follow the current state, one cycle behind it.
            if (state == DRIVE && lit) begin
                an_q  <= (4'b0001 << idx) ^ AN_OFF;
                seg_q <= hex7(nib) ^ SEG_OFF;
            end else begin
                an_q  <= AN_OFF;
                seg_q <= SEG_OFF;
            end
        end
    end

    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.digit_idx = idx;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver -- randomized self-checking bench for seg_scan_driver.
// A frame-level model (digit index, shadow, display) predicts what each scan
// step must show; the bench drives slowClk edges, loads, extra edges during
// blanking and a mid-DRIVE reset.
module tb_seg_scan_driver;
    localparam int BC = 16;

    logic clk100Mhz = 1'b0;
    logic reset;
    seg_scan_if bus ();

    seg_scan_driver #(.BLANK_CYCLES(BC), .ACTIVE_LOW(1)) dut (
        .clk100Mhz (clk100Mhz),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk100Mhz = ~clk100Mhz;

    // Active-high seven-segment patterns {g..a} for 0..F.
    logic [6:0] seg_ah [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_chk = 0;
    int n_pass = 0;

    int          m_idx;
    logic [15:0] m_shadow;
    logic [15:0] m_display;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_idx     = 3;
        m_shadow  = 16'h0000;
        m_display = 16'h0000;
    endtask

    // One scan step: raise slowClk, optionally pulse load at edge load_edge
    // (edges counted from the slowClk rise; 0 = no load), optionally inject a
    // second slowClk edge during blanking, keep slowClk high for dwell extra
    // cycles of DRIVE, then drop it.
    task automatic scan(input int load_edge, input logic [15:0] lval,
                        input bit glitch, input int dwell);
        int         old_idx, last;
        logic       blank_bad;
        logic [3:0] nib, ea;
        logic [6:0] es;
        bit         lit;

        old_idx = m_idx;
        m_idx   = (m_idx + 1) % 4;
        // Tick acts on the 3rd edge; a load on that same edge is too late for
        // this frame's copy.
        if (load_edge > 0 && load_edge < 3) m_shadow = lval;
        if (m_idx == 0) m_display = m_shadow;
        if (load_edge >= 3) m_shadow = lval;

        nib = m_display[m_idx*4 +: 4];
        lit = 1'b1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        lit = (m_idx == 0) || ((m_display >> (4*m_idx)) != 16'h0000);
`endif
        ea = lit ? ~(4'b0001 << m_idx) : 4'hF;
        es = ~seg_ah[nib];
        last = BC + 4 + dwell;
        blank_bad = 1'b0;

        @(negedge clk100Mhz);
        bus.slowClk = 1'b1;
        for (int e = 1; e <= last; e++) begin
            bus.load  = (e == load_edge);
            bus.value = lval;
            if (glitch && e == 6) bus.slowClk = 1'b0;
            if (glitch && e == 9) bus.slowClk = 1'b1;
            @(posedge clk100Mhz);
            #1;
            if (e == 2) chk("idx_before_tick", 32'(bus.digit_idx), 32'(old_idx));
            if (e == 3) chk("idx_on_tick", 32'(bus.digit_idx), 32'(m_idx));
            if (e >= 4 && e <= BC + 3 && bus.an !== 4'hF) blank_bad = 1'b1;
            if (e == BC + 3) chk("blank_window", 32'(blank_bad), 32'd0);
            if (e == BC + 4) begin
                chk("an_drive", 32'(bus.an), 32'(ea));
                if (lit) chk("seg_drive", 32'(bus.seg), 32'(es));
            end
            if (e == last) begin
                chk("idx_hold", 32'(bus.digit_idx), 32'(m_idx));
                chk("an_hold", 32'(bus.an), 32'(ea));
            end
            @(negedge clk100Mhz);
        end
        bus.load    = 1'b0;
        bus.slowClk = 1'b0;
        repeat (3) @(negedge clk100Mhz);
    endtask

    function automatic logic [15:0] rand_value();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 3))
            0: v &= 16'h000F;
            1: v &= 16'h00FF;
            2: v &= 16'h0FFF;
            default: ;
        endcase
        return v;
    endfunction

    task automatic scan_random();
        int dw, le;
        dw = $urandom_range(0, 6);
        le = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, BC + 4 + dw);
        scan(le, rand_value(), bit'($urandom_range(0, 1)), dw);
    endtask

    initial begin
        reset       = 1'b1;
        bus.slowClk = 1'b0;
        bus.load    = 1'b0;
        bus.value   = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk100Mhz);
        chk("rst_an", 32'(bus.an), 32'hF);
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        chk("rst_idx", 32'(bus.digit_idx), 32'd3);
        reset = 1'b0;
        repeat (2) @(negedge clk100Mhz);

        // Zero value through one full frame.
        for (int i = 0; i < 4; i++) scan(0, 16'h0000, 1'b0, 2);

        // Load mid-frame during digit 0, rest of frame stays old.
        scan(BC + 6, 16'h12AF, 1'b0, 5);
        for (int i = 0; i < 3; i++) scan(0, 16'h0000, 1'b0, 1);
        for (int i = 0; i < 4; i++) scan(0, 16'h0000, 1'b1, 1);

        // Load coincident with the wrap tick.
        scan(3, 16'hBEEF, 1'b0, 1);
        for (int i = 0; i < 3; i++) scan(0, 16'h0000, 1'b0, 0);
        for (int i = 0; i < 4; i++) scan(0, 16'h0000, 1'b0, 0);

        // Leading zeros.
        scan(1, 16'h0050, 1'b0, 1);
        for (int i = 0; i < 3; i++) scan(0, 16'h0000, 1'b0, 1);

        for (int i = 0; i < 40; i++) scan_random();

        // Reset during DRIVE of digit 2.
        while (m_idx != 2) scan_random();
        @(posedge clk100Mhz);
        #2 reset = 1'b1;
        #1;
        chk("midrst_an", 32'(bus.an), 32'hF);
        chk("midrst_seg", 32'(bus.seg), 32'h7F);
        chk("midrst_idx", 32'(bus.digit_idx), 32'd3);
        @(negedge clk100Mhz);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk100Mhz);
        scan(0, 16'h0000, 1'b0, 1);
        for (int i = 0; i < 8; i++) scan_random();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL provide parameter BLANK_CYCLES, default 16: number of clk100Mhz cycles all anodes stay off between digits (1..255).
REQ-002 SHALL provide parameter ACTIVE_LOW, default 1: 1 = anodes and segments active-low, 0 = active-high.
REQ-003 SHALL provide port clk100Mhz  input  1  fast system clock; every flop in the block runs on its rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port slowClk  input  1  scan-rate square wave from the clock divider; treated as data, never as a clock.
REQ-006 SHALL provide port value  input  16  four hex nibbles; value[3:0] is digit 0 (rightmost).
REQ-007 SHALL provide port load  input  1  single-cycle strobe that captures value into the shadow register.
REQ-008 SHALL provide port an  output  4  digit anode enables, one-hot when active.
REQ-009 SHALL provide port seg  output  7  segments in order {g,f,e,d,c,b,a}.
REQ-010 SHALL provide port digit_idx  output  2  index of the digit currently selected.

Function
REQ-011 SHALL pass slowClk through a two-flop synchronizer plus one history flop; scan_tick = sync2 AND NOT hist, a one-cycle pulse per slowClk rising edge.
REQ-012 SHALL assert scan_tick on the 3rd clk100Mhz rising edge after slowClk goes high (setup met); a slowClk high level without a new rising edge SHALL NOT produce a further tick.
REQ-013 SHALL implement FSM states IDLE, BLANK, DRIVE; IDLE->BLANK on scan_tick; BLANK->DRIVE after exactly BLANK_CYCLES cycles in BLANK; DRIVE->BLANK on scan_tick.
REQ-014 SHALL, on entry to BLANK, increment digit_idx modulo 4 (3 wraps to 0).
REQ-015 SHALL drive an and seg to the inactive level in IDLE and BLANK, and in DRIVE drive an one-hot at bit digit_idx and seg with the decoded nibble for digit_idx.
REQ-016 SHALL decode hex 0-F to standard seven-segment patterns; active-low examples: 0=1000000, 8=0000000, F=0001110; ACTIVE_LOW=0 inverts all patterns and anodes.
REQ-017 SHALL capture value into the shadow register on the cycle load is high, independent of FSM state.
REQ-018 SHALL copy the shadow register into the display register on the tick that wraps digit_idx from 3 to 0, so a frame never mixes two values.
REQ-019 SHALL, when load and the wrap tick coincide, copy the pre-load shadow contents; the new value appears on the following frame.
REQ-020 SHALL register an, seg and digit_idx; outputs change one cycle after the FSM state change that causes them.
REQ-021 SHALL, on a scan_tick arriving while in BLANK, ignore it (no index advance, blank count not restarted).

Reset
REQ-022 SHALL, while reset is high, immediately force: state IDLE, an inactive, seg inactive, digit_idx=3, shadow=0, display=0, synchronizer and history flops=0, blank counter=0.
REQ-023 SHALL, after reset deasserts, make the first scan_tick select digit 0 and load display from shadow.
REQ-024 SHALL, on reset assertion mid-DRIVE or mid-BLANK, drop all anodes within the same cycle, with no partial digit output.

Configuration
REQ-025 SHALL, with macro SEG_LEADING_ZERO_BLANK_EN defined, hold an inactive in DRIVE for any digit above 0 whose nibble and all higher nibbles are zero (value 0x0000 shows only digit 0).
REQ-026 SHALL, without SEG_LEADING_ZERO_BLANK_EN, light all four digits for every value, zeros included.

Verification
REQ-027 Reset, then 4 slowClk rising edges, value=0 -> digit_idx 0,1,2,3; an active-low 1110,1101,1011,0111; seg=1000000 in each DRIVE.
REQ-028 load with value=0x12AF mid-frame -> current frame unchanged; next frame shows F,A,2,1 on digits 0..3 (digit 0 seg=0001110).
REQ-029 Measure BLANK: with BLANK_CYCLES=16, an inactive exactly 16 cycles after each tick-triggered entry; extra slowClk edge injected during BLANK -> ignored.
REQ-030 load coincident with wrap tick -> old shadow displayed this frame, new value next frame.
REQ-031 reset pulse during DRIVE of digit 2 -> an=1111, seg=1111111 in that cycle; first tick after release selects digit 0.
REQ-032 With SEG_LEADING_ZERO_BLANK_EN, value=0x0050 -> digits 2,3 an stay 1111, digits 0,1 lit; without macro all four lit.
